instr_fetch_unit: RTL

//  Fetch stage directly downstream of program_counter. Takes pc, issues word reads to

---
 rtl/instr_fetch_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between program_counter and decode.
// Issues word reads for the current pc, tags each request with its pc, and
// buffers returned {pc, instr} pairs in a small FIFO. Responses for requests
// that were in flight when a redirect (flush) happened are counted and dropped.
// Optional build macro: IFU_MISALIGN_CHECK_EN -- a pc with pc[1:0]!=0 is not
// sent to memory; a NOP entry flagged misaligned is buffered in its place.
module instr_fetch_unit #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misaligned
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = CW + FW + 1;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [FW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   tag_mem    [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr;
    logic [TW-1:0] tag_rd;
    logic [OW-1:0] occupancy;
    logic          can_issue;
    logic          fire;
    logic          take;
    logic          pop;
    logic          resp_keep;
    logic          fifo_push;
    logic [31:0]   push_pc;
    logic [31:0]   push_instr;
`ifdef IFU_MISALIGN_CHECK_EN
    logic          fifo_mis   [FIFO_DEPTH];
    logic          mis_pend;
    logic          mis_take;
    logic          push_mis;
    logic [31:0]   mis_pc;
`endif

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    assign imem_req_addr = pc;
    assign if_valid      = (fifo_cnt != '0);
    assign if_pc         = fifo_pc[rd_ptr];
    assign if_instr      = fifo_instr[rd_ptr];

    // Issue credit: every live in-flight request already owns a FIFO slot.
    always_comb begin
        occupancy = OW'(outstanding) - OW'(discard) + OW'(fifo_cnt);
`ifdef IFU_MISALIGN_CHECK_EN
        occupancy = occupancy + OW'(mis_pend);
`endif
        can_issue = rst_n && !flush
                    && (outstanding < CW'(MAX_OUTSTANDING))
                    && (occupancy < OW'(FIFO_DEPTH));
`ifdef IFU_MISALIGN_CHECK_EN
        // A synthesized NOP waits until all live requests have returned so
        // that program order in the FIFO is preserved.
        can_issue      = can_issue && !mis_pend;
        mis_take       = can_issue && (pc[1:0] != 2'b00) && (outstanding == discard);
        imem_req_valid = can_issue && (pc[1:0] == 2'b00);
        fire           = imem_req_valid && imem_req_ready;
        take           = fire || mis_take;
`else
        imem_req_valid = can_issue;
        fire           = imem_req_valid && imem_req_ready;
        take           = fire;
`endif
        pc_en = take || (rst_n && flush);
    end

    // FIFO write source: a kept memory response or a pending misaligned NOP.
    always_comb begin
        resp_keep  = imem_resp_valid && !flush && (discard == '0);
        pop        = if_valid && if_ready;
        fifo_push  = resp_keep;
        push_pc    = tag_mem[tag_rd];
        push_instr = imem_resp_data;
`ifdef IFU_MISALIGN_CHECK_EN
        push_mis   = 1'b0;
        if (mis_pend && !flush) begin
            fifo_push  = 1'b1;
            push_pc    = mis_pc;
            push_instr = 32'h0000_0013;
            push_mis   = 1'b1;
        end
`endif
    end

    // In-flight count and the number of stale responses still to drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (fire && !imem_resp_valid)
                outstanding <= outstanding + CW'(1);
            else if (!fire && imem_resp_valid)
                outstanding <= outstanding - CW'(1);
            if (flush)
                discard <= outstanding - CW'(imem_resp_valid);
            else if (imem_resp_valid && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

    // pc-tag queue pointers; responses come back in request order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (fire)            tag_wr <= tag_inc(tag_wr);
            if (imem_resp_valid) tag_rd <= tag_inc(tag_rd);
        end
    end

    // pc-tag storage.
    always_ff @(posedge clk) begin
        if (fire) tag_mem[tag_wr] <= pc;
    end

    // Output FIFO pointers and occupancy; flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + FW'(fifo_push) - FW'(pop);
        end
    end

    // Output FIFO storage, cleared on reset so head outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
                fifo_mis[i]   <= 1'b0;
`endif
            end
        end else if (fifo_push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
`ifdef IFU_MISALIGN_CHECK_EN
            fifo_mis[wr_ptr]   <= push_mis;
`endif
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // One-cycle hold of a misaligned pc before its NOP entry is buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pend <= 1'b0;
            mis_pc   <= '0;
        end else begin
            mis_pend <= mis_take;
            if (mis_take) mis_pc <= pc;
        end
    end

    assign if_misaligned = fifo_mis[rd_ptr];
`else
    assign if_misaligned = 1'b0;
`endif

    // A write into a full buffer, or a response with nothing in flight,
    // means the credit accounting is broken.
    assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_push && !pop) |-> (fifo_cnt < FW'(FIFO_DEPTH)));
    assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding != '0));

endmodule
